sig_dump_monitor: RTL and testbench
===================================

SIG_DUMP_MONITOR -- requirements
Module: sig_dump_monitor

Interface
REQ-001 SHALL have parameter STOP_DRAIN_CYCLES, default 50, cycles run after a stop write before done.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, power of two >= 2, dump-record queue depth.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports mem_req_i/mem_we_i  input  1 each  SoC memory-port request and write enable.
REQ-006 SHALL have ports mem_addr_i, mem_wdata_i  input  64 each  SoC memory-port address and write data.
REQ-007 SHALL have port simlen_i  input  32  cycle budget; 0 disables the limit; sampled every cycle.
REQ-008 SHALL have ports dump_valid_o output 1, dump_ready_i input 1  dump-record handshake.
REQ-009 SHALL have ports dump_is_float_o output 1, dump_idx_o output 5, dump_data_o output 64  record fields.
REQ-010 SHALL have ports done_o output 1, done_cause_o output 2 (00 none, 01 stop, 10 simlen), trap_seen_o output 1.
REQ-011 SHALL have ports cycle_cnt_o output 32, drop_cnt_o output 16.

Function
REQ-012 SHALL treat a cycle with mem_req_i && mem_we_i as a "write"; address match SHALL be full 64-bit equality.
REQ-013 SHALL decode writes: 0x0 stop, 0x8 trap, 0x10 integer dump, 0x18 float dump; other addresses ignored.
REQ-014 SHALL implement FSM RUN -> DRAIN -> DONE; DONE SHALL be terminal until reset.
REQ-015 RUN: stop write SHALL load drain counter with STOP_DRAIN_CYCLES and enter DRAIN next cycle.
REQ-016 DRAIN: counter SHALL decrement each cycle; at 0, enter DONE with cause 01; a stop write in cycle T gives done_o high from cycle T+STOP_DRAIN_CYCLES+1.
REQ-017 cycle_cnt_o SHALL count from 0 at first cycle after reset release, increment every cycle in RUN/DRAIN, freeze in DONE.
REQ-018 When simlen_i != 0 and cycle_cnt_o == simlen_i-1 in RUN or DRAIN, SHALL enter DONE next cycle with cause 10.
REQ-019 Stop write and simlen match in same cycle: simlen SHALL win (cause 10); simlen match in DRAIN SHALL preempt drain.
REQ-020 Trap write in RUN SHALL set trap_seen_o sticky; SHALL NOT change FSM state.
REQ-021 Dump writes SHALL be processed only in RUN; writes in DRAIN/DONE ignored entirely (no push, no index change).
REQ-022 Integer index SHALL start at 1, float index at 0; each SHALL increment by 1 per matching dump write, wrapping 31->0.
REQ-023 Each dump write SHALL push record {is_float, current index, wdata} into the FIFO; index advances whether or not push succeeds.
REQ-024 Push SHALL succeed if FIFO not full, or full with a pop in the same cycle; otherwise record dropped and drop_cnt_o incremented, saturating at 0xFFFF.
REQ-025 dump_valid_o SHALL equal FIFO non-empty; pop on dump_valid_o && dump_ready_i; record fields stable while valid && !ready.
REQ-026 Push-to-valid latency SHALL be 1 cycle (record written at edge, visible next cycle); simultaneous push and pop when empty SHALL not bypass.
REQ-027 FIFO SHALL continue draining in DRAIN and DONE.
REQ-028 done_o SHALL be registered, high iff state is DONE.

Reset
REQ-029 Reset asserted SHALL asynchronously force: state RUN, done_o 0, done_cause_o 00, trap_seen_o 0, cycle_cnt_o 0, drop_cnt_o 0, FIFO empty (dump_valid_o 0), int index 1, float index 0.
REQ-030 Reset mid-drain or with a non-empty FIFO SHALL discard all pending state; no record emitted after reset.

Structure
REQ-031 SHALL place address constants, state enum, cause enum and dump-record struct in package sig_monitor_pkg.
REQ-032 SHALL instantiate one sub-module dump_fifo (parameterised depth and element type, full/empty flags, pointers with wrap bit).

Verification
REQ-033 simlen_i=0; stop write at cycle 10, STOP_DRAIN_CYCLES=50 -> done_o rises at cycle 61, cause 01, cycle_cnt_o frozen at 60.
REQ-034 simlen_i=100, no stop -> done_o rises cycle 100, cause 10; stop write at cycle 99 -> still cause 10.
REQ-035 Three int dumps (0xA,0xB,0xC) then one float dump (0xD), dump_ready_i=1 -> records (0,1,0xA),(0,2,0xB),(0,3,0xC),(1,0,0xD) in order, each 1 cycle after write.
REQ-036 dump_ready_i=0, FIFO_DEPTH=8, 10 int dumps -> 8 records held, drop_cnt_o=2; after release, indices 1..8 then next dump carries index 11.
REQ-037 Trap write at cycle 5, dump write during DRAIN -> trap_seen_o=1, FSM unchanged, no record pushed.
REQ-038 Reset asserted mid-DRAIN with 4 queued records -> all outputs at reset values immediately, FIFO empty, indices restart at 1/0.

Source files
------------

// File: rtl/sig_monitor_pkg.sv
// Shared types and constants for the signature/dump monitor: decoded write
// addresses, FSM states, completion causes and the queued dump record.
package sig_monitor_pkg;

  localparam logic [63:0] ADDR_STOP      = 64'h0000_0000_0000_0000;
  localparam logic [63:0] ADDR_TRAP      = 64'h0000_0000_0000_0008;
  localparam logic [63:0] ADDR_DUMP_INT  = 64'h0000_0000_0000_0010;
  localparam logic [63:0] ADDR_DUMP_FLT  = 64'h0000_0000_0000_0018;

  localparam logic [4:0]  INT_IDX_RST    = 5'd1;
  localparam logic [4:0]  FLT_IDX_RST    = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_STOP   = 2'b01,
    CAUSE_SIMLEN = 2'b10
  } cause_t;

  typedef struct packed {
    logic        is_float;
    logic [4:0]  idx;
    logic [63:0] data;
  } dump_rec_t;

endpackage

// File: rtl/sig_dump_monitor_fifo.sv
// Synchronous FIFO for dump records; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module dump_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T             mem [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push into a full queue is allowed when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign data_o  = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/sig_dump_monitor.sv
// Watches SoC memory-port writes for stop/trap/dump addresses, sequences
// RUN -> DRAIN -> DONE, and queues dump records for a downstream consumer.
//
// state    | meaning
// ---------|---------------------------------------------------------------
// ST_RUN   | normal operation; stop, trap and dump writes are decoded
// ST_DRAIN | stop seen; counting down the drain window, writes ignored
// ST_DONE  | terminal until reset; cycle counter frozen, FIFO still drains
module sig_dump_monitor
  import sig_monitor_pkg::*;
#(
  parameter int unsigned STOP_DRAIN_CYCLES = 50,
  parameter int unsigned FIFO_DEPTH        = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [63:0] mem_addr_i,
  input  logic [63:0] mem_wdata_i,
  input  logic [31:0] simlen_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic        dump_is_float_o,
  output logic [4:0]  dump_idx_o,
  output logic [63:0] dump_data_o,
  output logic        done_o,
  output logic [1:0]  done_cause_o,
  output logic        trap_seen_o,
  output logic [31:0] cycle_cnt_o,
  output logic [15:0] drop_cnt_o
);

  localparam logic [31:0] DRAIN_LOAD = 32'(STOP_DRAIN_CYCLES);

  state_t      state_q;
  state_t      state_d;
  cause_t      cause_q;
  cause_t      cause_d;
  logic [31:0] drain_q;
  logic [31:0] drain_d;
  logic [31:0] cycle_cnt_q;
  logic        done_q;
  logic        trap_q;
  logic [15:0] drop_q;
  logic [4:0]  int_idx_q;
  logic [4:0]  flt_idx_q;

  logic        wr;
  logic        in_run;
  logic        stop_wr;
  logic        trap_wr;
  logic        int_wr;
  logic        flt_wr;
  logic        dump_wr;
  logic        simlen_hit;

  dump_rec_t   push_rec;
  dump_rec_t   head_rec;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        dropped;

  assign wr         = mem_req_i && mem_we_i;
  assign in_run     = (state_q == ST_RUN);
  assign stop_wr    = wr && (mem_addr_i == ADDR_STOP);
  assign trap_wr    = wr && (mem_addr_i == ADDR_TRAP);
  assign int_wr     = wr && (mem_addr_i == ADDR_DUMP_INT);
  assign flt_wr     = wr && (mem_addr_i == ADDR_DUMP_FLT);
  assign dump_wr    = in_run && (int_wr || flt_wr);
  assign simlen_hit = (simlen_i != 32'd0) && (cycle_cnt_q == simlen_i - 32'd1);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    drain_d = drain_q;
    case (state_q)
      ST_RUN: begin
        // The cycle budget outranks a stop arriving in the same cycle.
        if (simlen_hit) begin
          state_d = ST_DONE;
          cause_d = CAUSE_SIMLEN;
        end else if (stop_wr) begin
          drain_d = DRAIN_LOAD;
          if (DRAIN_LOAD == 32'd0) begin
            state_d = ST_DONE;
            cause_d = CAUSE_STOP;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (simlen_hit) begin
          state_d = ST_DONE;
          cause_d = CAUSE_SIMLEN;
        end else begin
          drain_d = drain_q - 32'd1;
          if (drain_q == 32'd1) begin
            state_d = ST_DONE;
            cause_d = CAUSE_STOP;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      cause_q <= CAUSE_NONE;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      drain_q <= drain_d;
      done_q  <= (state_d == ST_DONE);
    end
  end

  // The counter holds the index of the last active cycle once DONE is reached.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_q <= '0;
      trap_q      <= 1'b0;
    end else begin
      if ((state_q != ST_DONE) && (state_d != ST_DONE)) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end
      if (in_run && trap_wr) begin
        trap_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      int_idx_q <= INT_IDX_RST;
      flt_idx_q <= FLT_IDX_RST;
      drop_q    <= '0;
    end else begin
      if (in_run && int_wr) begin
        int_idx_q <= int_idx_q + 5'd1;
      end
      if (in_run && flt_wr) begin
        flt_idx_q <= flt_idx_q + 5'd1;
      end
      if (dropped && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign push_rec = '{is_float: flt_wr,
                      idx:      flt_wr ? flt_idx_q : int_idx_q,
                      data:     mem_wdata_i};

  assign pop     = !fifo_empty && dump_ready_i;
  assign dropped = dump_wr && fifo_full && !pop;

  dump_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (dump_rec_t)
  ) u_dump_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (dump_wr),
    .data_i  (push_rec),
    .pop_i   (pop),
    .data_o  (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign dump_valid_o    = !fifo_empty;
  assign dump_is_float_o = head_rec.is_float;
  assign dump_idx_o      = head_rec.idx;
  assign dump_data_o     = head_rec.data;
  assign done_o          = done_q;
  assign done_cause_o    = cause_q;
  assign trap_seen_o     = trap_q;
  assign cycle_cnt_o     = cycle_cnt_q;
  assign drop_cnt_o      = drop_q;

endmodule

// File: tb/tb_sig_dump_monitor.sv
// Directed and randomized bench for sig_dump_monitor against a queue-based
// reference model that derives completion times arithmetically.
module tb_sig_dump_monitor;

  localparam int N     = 50;
  localparam int DEPTH = 8;
  localparam int INF   = 32'h3FFF_FFFF;

  localparam logic [63:0] A_STOP = 64'h00;
  localparam logic [63:0] A_TRAP = 64'h08;
  localparam logic [63:0] A_INT  = 64'h10;
  localparam logic [63:0] A_FLT  = 64'h18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [63:0] mem_addr = '0;
  logic [63:0] mem_wdata = '0;
  logic [31:0] simlen = '0;
  logic        dump_ready = 1'b0;
  logic        dump_valid;
  logic        dump_is_float;
  logic [4:0]  dump_idx;
  logic [63:0] dump_data;
  logic        done;
  logic [1:0]  done_cause;
  logic        trap_seen;
  logic [31:0] cycle_cnt;
  logic [15:0] drop_cnt;

  sig_dump_monitor #(
    .STOP_DRAIN_CYCLES (N),
    .FIFO_DEPTH        (DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .mem_req_i       (mem_req),
    .mem_we_i        (mem_we),
    .mem_addr_i      (mem_addr),
    .mem_wdata_i     (mem_wdata),
    .simlen_i        (simlen),
    .dump_valid_o    (dump_valid),
    .dump_ready_i    (dump_ready),
    .dump_is_float_o (dump_is_float),
    .dump_idx_o      (dump_idx),
    .dump_data_o     (dump_data),
    .done_o          (done),
    .done_cause_o    (done_cause),
    .trap_seen_o     (trap_seen),
    .cycle_cnt_o     (cycle_cnt),
    .drop_cnt_o      (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          f;
    int          idx;
    logic [63:0] d;
  } rec_t;

  rec_t q[$];
  int   cyc;
  int   stop_done;
  int   simlen_done;
  int   drops;
  int   int_idx;
  int   flt_idx;
  bit   stopped;
  bit   trap;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int done_at();
    return (simlen_done < stop_done) ? simlen_done : stop_done;
  endfunction

  task automatic model_reset(input logic [31:0] sl);
    q.delete();
    cyc         = 0;
    stopped     = 1'b0;
    trap        = 1'b0;
    stop_done   = INF;
    simlen_done = (sl == 32'd0) ? INF : int'(sl);
    drops       = 0;
    int_idx     = 1;
    flt_idx     = 0;
  endtask

  task automatic check_all();
    bit is_done;
    is_done = (cyc >= done_at());
    chk("done", done, is_done);
    chk("cause", done_cause, !is_done ? 0 : ((simlen_done <= stop_done) ? 2 : 1));
    chk("trap", trap_seen, trap);
    chk("cycle_cnt", cycle_cnt, is_done ? done_at() - 1 : cyc);
    chk("drop_cnt", drop_cnt, drops);
    chk("valid", dump_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("is_float", dump_is_float, q[0].f);
      chk("idx", dump_idx, q[0].idx);
      chk("data", dump_data, q[0].d);
    end
  endtask

  // Drives one cycle of inputs, advances the model by that cycle, then checks.
  task automatic step(input bit req, input bit we, input logic [63:0] a,
                      input logic [63:0] d, input bit rdy);
    bit   run;
    rec_t r;
    mem_req    = req;
    mem_we     = we;
    mem_addr   = a;
    mem_wdata  = d;
    dump_ready = rdy;
    run = !stopped && (cyc < done_at());
    if ((q.size() > 0) && rdy) void'(q.pop_front());
    if (run && req && we) begin
      if (a == A_STOP) begin
        stopped   = 1'b1;
        stop_done = cyc + N + 1;
      end else if (a == A_TRAP) begin
        trap = 1'b1;
      end else if ((a == A_INT) || (a == A_FLT)) begin
        r.f   = (a == A_FLT);
        r.idx = r.f ? flt_idx : int_idx;
        r.d   = d;
        if (r.f) flt_idx = (flt_idx + 1) % 32;
        else     int_idx = (int_idx + 1) % 32;
        if (q.size() < DEPTH) q.push_back(r);
        else if (drops < 65535) drops = drops + 1;
      end
    end
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    check_all();
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 64'h0, 64'h0, rdy);
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d, input bit rdy);
    step(1'b1, 1'b1, a, d, rdy);
  endtask

  task automatic do_reset(input logic [31:0] sl);
    #2;
    rst_n      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    dump_ready = 1'b0;
    simlen     = sl;
    #1;
    chk("rst_done", done, 1'b0);
    chk("rst_cause", done_cause, 2'b00);
    chk("rst_trap", trap_seen, 1'b0);
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    chk("rst_drop_cnt", drop_cnt, 16'd0);
    chk("rst_valid", dump_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset(sl);
    check_all();
  endtask

  initial begin
    // Ordered int/float dumps, trap, stop and ignored dump during drain.
    do_reset(32'd0);
    wr(A_INT, 64'hA, 1'b1);
    wr(A_INT, 64'hB, 1'b1);
    wr(A_INT, 64'hC, 1'b1);
    wr(A_FLT, 64'hD, 1'b1);
    idle(1'b1);
    wr(A_TRAP, 64'h1, 1'b1);
    chk("trap_sticky", trap_seen, 1'b1);
    chk("trap_no_done", done, 1'b0);
    while (cyc < 10) idle(1'b1);
    wr(A_STOP, 64'h0, 1'b1);
    wr(A_INT, 64'hEE, 1'b0);
    chk("drain_dump_ignored", dump_valid, 1'b0);
    while (cyc < 70) begin
      idle(1'b1);
      if (cyc == 60) chk("stop_not_yet_done", done, 1'b0);
      if (cyc == 61) begin
        chk("stop_done_61", done, 1'b1);
        chk("stop_cause", done_cause, 2'b01);
        chk("stop_cnt_frozen", cycle_cnt, 32'd60);
      end
    end
    wr(A_INT, 64'h55, 1'b1);
    chk("done_dump_ignored", dump_valid, 1'b0);

    // Back-pressure: 10 dumps into an 8-deep queue, then release.
    do_reset(32'd0);
    for (int i = 0; i < 10; i++) wr(A_INT, 64'h100 + 64'(i), 1'b0);
    repeat (3) idle(1'b0);
    chk("bp_drops", drop_cnt, 16'd2);
    chk("bp_head_idx", dump_idx, 5'd1);
    repeat (10) idle(1'b1);
    wr(A_INT, 64'h200, 1'b1);
    chk("bp_next_idx", dump_idx, 5'd11);
    idle(1'b1);

    // Cycle budget alone, then a stop in the final budget cycle.
    do_reset(32'd100);
    while (cyc < 105) begin
      idle(1'b1);
      if (cyc == 100) begin
        chk("simlen_done", done, 1'b1);
        chk("simlen_cause", done_cause, 2'b10);
      end
    end
    do_reset(32'd100);
    while (cyc < 99) idle(1'b1);
    wr(A_STOP, 64'h0, 1'b1);
    chk("simlen_vs_stop", done_cause, 2'b10);
    repeat (3) idle(1'b1);

    // Reset while draining with four queued records.
    do_reset(32'd0);
    for (int i = 0; i < 4; i++) wr(A_INT, 64'h300 + 64'(i), 1'b0);
    wr(A_STOP, 64'h0, 1'b0);
    repeat (5) idle(1'b0);
    do_reset(32'd0);
    repeat (2) idle(1'b1);
    wr(A_INT, 64'h400, 1'b1);
    chk("rst_int_idx", dump_idx, 5'd1);
    wr(A_FLT, 64'h401, 1'b1);
    chk("rst_flt_idx", dump_idx, 5'd0);
    repeat (2) idle(1'b1);

    // Randomized traffic against the model.
    for (int run_i = 0; run_i < 3; run_i++) begin
      logic [31:0] sl;
      sl = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(30, 160));
      do_reset(sl);
      for (int i = 0; i < 180; i++) begin
        int          r;
        logic [63:0] d;
        bit          rdy;
        r   = $urandom_range(0, 99);
        d   = {$urandom, $urandom};
        rdy = ($urandom_range(0, 3) != 0);
        if (r < 35)      wr(A_INT, d, rdy);
        else if (r < 55) wr(A_FLT, d, rdy);
        else if (r < 58) wr(A_TRAP, d, rdy);
        else if (r < 61) wr(64'h1_0000_0010, d, rdy);
        else if (r < 63) wr({$urandom, $urandom}, d, rdy);
        else if (r < 68) step(1'b1, 1'b0, A_INT, d, rdy);
        else if (r < 72) step(1'b0, 1'b1, A_FLT, d, rdy);
        else if (r == 99) wr(A_STOP, d, rdy);
        else             idle(rdy);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
